// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl
//   Drives the ECP5 EHXPLLL dynamic phase-adjust port in response to
//   phase-shift requests. Each request names an output, a direction and
//   a number of steps. For every step the block sets PHASESEL/PHASEDIR,
//   pulses PHASESTEP low, lets the PLL settle and then waits for re-lock.
//   A per-output phase position counter, modulo PHASE_MOD, is kept.
//
// Ports
//   clk         25 MHz input clock
//   rst         synchronous active-high reset
//   req_valid   request valid
//   req_ready   high in IDLE; a request is accepted on req_valid && req_ready
//   req_sel     output select (0 CLKOS, 1 CLKOS2, 2 CLKOS3, 3 CLKOP)
//   req_dir     1 = advance (+1 per step), 0 = delay (-1 per step)
//   req_steps   number of phase steps, 0..255
//   pll_locked  PLL LOCK, asynchronous to clk
//   phasesel    PLL PHASESEL[1:0]
//   phasedir    PLL PHASEDIR
//   phasestep   PLL PHASESTEP, idle high, low during a step pulse
//   busy        a sequence is in progress
//   done        one-cycle pulse, request completed
//   err         one-cycle pulse, lock timeout and request aborted
//   phase_pos   packed phase counters, [8*i+7:8*i] for output i
module pll_phase_ctrl #(
  parameter int unsigned SETUP_CYC    = 4,
  parameter int unsigned PULSE_CYC    = 4,
  parameter int unsigned SETTLE_CYC   = 16,
  parameter int unsigned LOCK_TIMEOUT = 1023,
  parameter int unsigned PHASE_MOD    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_sel,
  input  logic        req_dir,
  input  logic [7:0]  req_steps,
  input  logic        pll_locked,
  output logic [1:0]  phasesel,
  output logic        phasedir,
  output logic        phasestep,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] phase_pos
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    SETTLE,
    WAITLOCK,
    FIN
  } state_t;

  localparam logic [15:0] SETUP_LAST  = 16'(SETUP_CYC - 1);
  localparam logic [15:0] PULSE_LAST  = 16'(PULSE_CYC - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]  POS_MAX     = 8'(PHASE_MOD - 1);

  state_t      state;
  state_t      state_d;
  logic        lock_m;
  logic        lock_s;
  logic [15:0] cnt;
  logic [7:0]  remaining;
  logic [7:0]  pos [4];
  logic [7:0]  pos_next;
  logic        accept;
  logic        step_end;

  // Next state and strobes. err is decoded from the last WAITLOCK cycle so
  // it is raised while busy is still high and never overlaps a new accept.
  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    step_end = 1'b0;
    err      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = (req_steps == '0) ? FIN : SETUP;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) state_d = PULSE;
      end
      PULSE: begin
        if (cnt == PULSE_LAST) begin
          step_end = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) state_d = WAITLOCK;
      end
      WAITLOCK: begin
        if (lock_s) begin
          state_d = (remaining != '0) ? SETUP : FIN;
        end else if (cnt == LOCK_LAST) begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign req_ready = (state == IDLE);
  assign done      = (state == FIN);

  // phasesel/phasedir double as the latched select/direction.
  always_comb begin
    pos_next = pos[phasesel];
    if (phasedir) begin
      pos_next = (pos[phasesel] == POS_MAX) ? '0 : pos[phasesel] + 8'd1;
    end else begin
      pos_next = (pos[phasesel] == '0) ? POS_MAX : pos[phasesel] - 8'd1;
    end
  end

  always_comb begin
    phase_pos = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      phase_pos[8*i +: 8] = pos[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lock_m    <= 1'b0;
      lock_s    <= 1'b0;
      cnt       <= '0;
      remaining <= '0;
      phasesel  <= '0;
      phasedir  <= 1'b0;
      phasestep <= 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
        pos[i] <= '0;
      end
    end else begin
      state  <= state_d;
      lock_m <= pll_locked;
      lock_s <= lock_m;
      // Registered from the next state so PHASESTEP is glitch-free at the
      // PLL pin while still following PULSE cycle-for-cycle.
      phasestep <= (state_d != PULSE);
      // Per-state cycle counter restarts on every state change.
      if ((state_d != state) || (state == IDLE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
      if (accept) begin
        remaining <= req_steps;
        if (req_steps != '0) begin
          phasesel <= req_sel;
          phasedir <= req_dir;
        end
      end
      if (step_end) begin
        remaining     <= remaining - 8'd1;
        pos[phasesel] <= pos_next;
      end
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
module tb_pll_phase_ctrl;

  localparam int unsigned SETUP_CYC    = 4;
  localparam int unsigned PULSE_CYC    = 4;
  localparam int unsigned SETTLE_CYC   = 16;
  localparam int unsigned LOCK_TIMEOUT = 1023;
  localparam int unsigned PHASE_MOD    = 16;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_sel;
  logic        req_dir;
  logic [7:0]  req_steps;
  logic        pll_locked;
  logic [1:0]  phasesel;
  logic        phasedir;
  logic        phasestep;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] phase_pos;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  pll_phase_ctrl #(
    .SETUP_CYC   (SETUP_CYC),
    .PULSE_CYC   (PULSE_CYC),
    .SETTLE_CYC  (SETTLE_CYC),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .PHASE_MOD   (PHASE_MOD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_dir   (req_dir),
    .req_steps (req_steps),
    .pll_locked(pll_locked),
    .phasesel  (phasesel),
    .phasedir  (phasedir),
    .phasestep (phasestep),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .phase_pos (phase_pos)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_wait(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: bound expired, got no event, expected event at %0t", name, $time);
  endtask

  // Reference model: a timeline of per-cycle records describing what each
  // upcoming cycle of a request must look like, plus arithmetic phase counters.
  typedef enum int {K_SETUP, K_PULSE, K_SETTLE, K_WAIT, K_FIN} kind_t;
  typedef struct {
    kind_t kind;
    bit    apply;
  } rec_t;

  rec_t        q[$];
  int          m_pos [4];
  int          m_sel;
  int          m_dir;
  int          m_rem;
  int unsigned wait_cnt;
  bit          ls1;
  bit          ls2;
  bit          model_on = 1'b0;

  int unsigned n_done   = 0;
  int unsigned n_err    = 0;
  int unsigned n_pulses = 0;
  int unsigned n_low    = 0;
  bit          prev_ps  = 1'b1;

  function automatic rec_t mk(input kind_t k, input bit a);
    rec_t r;
    r.kind  = k;
    r.apply = a;
    return r;
  endfunction

  function automatic void push_step();
    for (int i = 0; i < int'(SETUP_CYC); i++) q.push_back(mk(K_SETUP, 1'b0));
    for (int i = 0; i < int'(PULSE_CYC); i++) q.push_back(mk(K_PULSE, i == int'(PULSE_CYC) - 1));
    for (int i = 0; i < int'(SETTLE_CYC); i++) q.push_back(mk(K_SETTLE, 1'b0));
    q.push_back(mk(K_WAIT, 1'b0));
  endfunction

  always @(negedge clk) begin : model_cmp
    logic [7:0]  exp_ctrl;
    logic [31:0] exp_pos;
    logic        exp_err;
    if (model_on) begin
      exp_err = 1'b0;
      if (q.size() == 0) begin
        exp_ctrl = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'(m_dir), 2'(m_sel)};
      end else begin
        exp_err  = (q[0].kind == K_WAIT) && !ls2 && (wait_cnt == LOCK_TIMEOUT - 1);
        exp_ctrl = {1'b0, 1'b1, 1'(q[0].kind == K_FIN), exp_err,
                    1'(q[0].kind != K_PULSE), 1'(m_dir), 2'(m_sel)};
      end
      exp_pos = '0;
      for (int i = 0; i < 4; i++) exp_pos[8*i +: 8] = 8'(m_pos[i]);
      check("ctrl{ready,busy,done,err,step,dir,sel}",
            32'({req_ready, busy, done, err, phasestep, phasedir, phasesel}), 32'(exp_ctrl));
      check("phase_pos", phase_pos, exp_pos);
      if (done === 1'b1) n_done++;
      if (err === 1'b1) n_err++;
      if (phasestep === 1'b0) begin
        n_low++;
        if (prev_ps) n_pulses++;
      end
      prev_ps = (phasestep !== 1'b0);
    end
    // advance the model across the coming clock edge
    if (rst) begin
      q.delete();
      for (int i = 0; i < 4; i++) m_pos[i] = 0;
      m_sel    = 0;
      m_dir    = 0;
      m_rem    = 0;
      wait_cnt = 0;
      ls1      = 1'b0;
      ls2      = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      if (q.size() == 0) begin
        if (req_valid) begin
          if (req_steps == 8'd0) begin
            q.push_back(mk(K_FIN, 1'b0));
          end else begin
            m_sel = int'(req_sel);
            m_dir = int'(req_dir);
            m_rem = int'(req_steps);
            push_step();
          end
        end
      end else if (q[0].kind == K_WAIT) begin
        if (ls2) begin
          void'(q.pop_front());
          wait_cnt = 0;
          if (m_rem > 0) push_step();
          else q.push_back(mk(K_FIN, 1'b0));
        end else if (wait_cnt == LOCK_TIMEOUT - 1) begin
          q.delete();
          wait_cnt = 0;
          m_rem    = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        if (q[0].apply) begin
          if (m_dir != 0) m_pos[m_sel] = (m_pos[m_sel] + 1) % int'(PHASE_MOD);
          else m_pos[m_sel] = (m_pos[m_sel] + int'(PHASE_MOD) - 1) % int'(PHASE_MOD);
          m_rem--;
        end
        void'(q.pop_front());
      end
      ls2 = ls1;
      ls1 = pll_locked;
    end
  end

  task automatic do_req(input logic [1:0] s, input logic d, input logic [7:0] n);
    int unsigned k;
    k = 0;
    while (!req_ready && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    if (!req_ready) fail_wait("req_ready");
    req_sel   = s;
    req_dir   = d;
    req_steps = n;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_sel   = 2'($urandom);
    req_dir   = 1'($urandom);
    req_steps = 8'($urandom);
  endtask

  // lock_mode: 0 leave pll_locked alone, 1 random dropouts, 2 forced low
  task automatic wait_idle(input int unsigned bound, input int lock_mode);
    int unsigned k;
    k = 0;
    while (busy && k < bound) begin
      if (lock_mode == 1) pll_locked = ($urandom_range(0, 9) != 0);
      else if (lock_mode == 2) pll_locked = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    if (busy) fail_wait("idle");
    if (lock_mode != 0) pll_locked = 1'b1;
  endtask

  task automatic wait_pos(input int idx, input int val);
    int unsigned k;
    k = 0;
    while (phase_pos[8*idx +: 8] != 8'(val) && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    if (phase_pos[8*idx +: 8] != 8'(val)) fail_wait("phase_pos step");
  endtask

  task automatic wait_ps_low();
    int unsigned k;
    k = 0;
    while (phasestep !== 1'b0 && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    if (phasestep !== 1'b0) fail_wait("phasestep low");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d0, e0, p0, l0, k;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_sel    = '0;
    req_dir    = 1'b0;
    req_steps  = '0;
    pll_locked = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset phasestep", 32'(phasestep), 32'd1);
    check("reset phasesel", 32'(phasesel), 32'd0);
    check("reset phase_pos", phase_pos, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // three advance steps on CLKOS2
    d0 = n_done; p0 = n_pulses; l0 = n_low;
    do_req(2'd1, 1'b1, 8'd3);
    wait_idle(2000, 0);
    check("t1 phase_pos[15:8]", 32'(phase_pos[15:8]), 32'd3);
    check("t1 pulse count", p0 == n_pulses ? 32'd0 : n_pulses - p0, 32'd3);
    check("t1 low cycles", n_low - l0, 32'd12);
    check("t1 done count", n_done - d0, 32'd1);
    check("t1 phasesel/dir", 32'({phasesel, phasedir}), 32'(3'b011));

    // wrap below zero and back
    do_req(2'd0, 1'b0, 8'd1);
    wait_idle(2000, 0);
    check("t2 delay wrap", 32'(phase_pos[7:0]), 32'd15);
    do_req(2'd0, 1'b1, 8'd1);
    wait_idle(2000, 0);
    check("t2 advance wrap", 32'(phase_pos[7:0]), 32'd0);

    // zero-step request: FIN only, select/direction untouched
    p0 = n_pulses;
    do_req(2'd2, 1'b0, 8'd0);
    check("t3 fin busy+done", 32'({busy, done}), 32'(2'b11));
    @(posedge clk); #1;
    check("t3 idle after fin", 32'({busy, req_ready}), 32'(2'b01));
    check("t3 no pulses", n_pulses - p0, 32'd0);
    check("t3 sel/dir held", 32'({phasesel, phasedir}), 32'(3'b001));

    // lock lost from step 2 of 4 -> timeout
    d0 = n_done; e0 = n_err;
    do_req(2'd2, 1'b1, 8'd4);
    wait_pos(2, 1);
    wait_ps_low();
    pll_locked = 1'b0;
    wait_idle(3000, 0);
    check("t4 err count", n_err - e0, 32'd1);
    check("t4 done count", n_done - d0, 32'd0);
    check("t4 phase_pos[23:16]", 32'(phase_pos[23:16]), 32'd2);
    check("t4 req_ready", 32'(req_ready), 32'd1);
    pll_locked = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // reset during the pulse of step 2 of 5
    d0 = n_done; e0 = n_err;
    do_req(2'd3, 1'b1, 8'd5);
    wait_pos(3, 1);
    wait_ps_low();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5 phasestep", 32'(phasestep), 32'd1);
    check("t5 busy", 32'(busy), 32'd0);
    check("t5 phase_pos", phase_pos, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("t5 no done/err", (n_done - d0) + (n_err - e0), 32'd0);

    // req_valid held with a different request while busy
    req_sel = 2'd2; req_dir = 1'b1; req_steps = 8'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_sel = 2'd3; req_dir = 1'b0; req_steps = 8'd1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done !== 1'b1 && k < 2000);
    if (done !== 1'b1) fail_wait("t6 done");
    check("t6 phase_pos[23:16]", 32'(phase_pos[23:16]), 32'd2);
    @(negedge clk);
    check("t6 idle cycle", 32'({req_ready, busy}), 32'(2'b10));
    @(negedge clk);
    check("t6 second accepted", 32'({busy, phasesel, phasedir}), 32'(4'b1110));
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle(2000, 0);
    check("t6 phase_pos[31:24]", 32'(phase_pos[31:24]), 32'd15);

    // randomized requests with lock dropouts and one forced timeout
    for (int i = 0; i < 30; i++) begin
      do_req(2'($urandom), 1'($urandom), 8'($urandom_range(0, 5)));
      wait_idle(3000, (i == 20) ? 2 : 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
